multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle main controller. A Moore FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Supports R, I-ALU, LW, SW, BEQ-class branch, JAL, JALR and LUI.
- Waits on a memory ready handshake and guards every memory wait with a timeout.
- Sits between the instruction register and the datapath. Drives PC/IR write enables, ALU, memory and writeback controls.

Parameters:
OPCODE_W, 7, width of opcode field
ALUOP_W, 2, width of alu_op output
TIMEOUT_CYC, 15, max cycles waiting on mem_ready before trap (1..2^CNT_W-1)
CNT_W, 4, width of wait counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  OPCODE_W  opcode from instruction register, stable from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC update (fetch PC+4, jump target)
ir_write  out  1  latch fetched instruction into IR
branch  out  1  conditional PC update if ALU zero
jump  out  1  EXEC is a JAL/JALR (target select)
alu_src  out  1  0 = rs2, 1 = immediate
alu_op  out  ALUOP_W  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write
wb_sel  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate
retire  out  1  one-cycle pulse on the last cycle of each instruction
trap  out  1  sticky: illegal opcode or memory timeout
trap_cause  out  1  0 = illegal opcode, 1 = timeout (valid while trap)

Behaviour:
- Reset (reset low, async):
  - State goes to FETCH; op_q and wait counter clear.
  - trap, trap_cause and all outputs are 0, except mem_read, which FETCH drives high combinationally.
- Outputs are Moore, decoded from state and op_q. There are no registered output delays.
- FETCH:
  - Drives mem_read=1.
  - When mem_ready=1: pc_write=1 and ir_write=1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE:
  - Latches opcode into op_q.
  - Unknown opcode: go to TRAP with trap_cause=0.
  - Known opcode: go to EXEC.
- EXEC:
  - alu_src=1 for I-ALU, LW, SW, JALR and LUI.
  - alu_op: 10 for R, 11 for I-ALU, 01 for branch, 00 otherwise.
  - Branch: branch=1, retire=1, next state FETCH.
  - JAL/JALR: jump=1 and pc_write=1, next state WB.
  - LW/SW: next state MEM.
  - R, I-ALU, LUI: next state WB.
- MEM:
  - Drives mem_read=1 for LW, or mem_write=1 for SW, and holds it until mem_ready.
  - When mem_ready arrives: LW goes to WB; SW pulses retire and goes to FETCH.
- WB:
  - Drives reg_write=1.
  - wb_sel: 00 for R/I-ALU, 01 for LW, 10 for JAL/JALR, 11 for LUI.
  - Pulses retire, then goes to FETCH.
- Latency with mem_ready tied high:
  - Branch: 3 cycles.
  - SW, R, I-ALU, LUI, JAL, JALR: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH or MEM and whenever mem_ready=1.
  - Saturates; never wraps.
- Timeout:
  - If the counter reaches TIMEOUT_CYC while mem_ready is still 0, the next state is TRAP with trap_cause=1.
  - If mem_ready=1 in the same cycle the threshold is reached, mem_ready wins and the access completes.
- TRAP:
  - Absorbing state; all enables are 0 and trap=1.
  - Exit only via reset.
- Reset mid-instruction: aborts immediately; no partial reg_write or mem_write is held.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - Opcode constants: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
  - state_t enum: FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - alu_op and wb_sel encodings.
- One sub-module, ctrl_wait_timer, implements the saturating counter with clear, enable and a timeout flag.

Test Plan:
- Reset low mid-MEM of SW -> mem_write=0 asynchronously; state FETCH; trap=0.
- mem_ready=1 constantly; sequence R, LW, SW, BR, JAL, LUI -> retire pulses after 4, 5, 4, 3, 4 and 4 cycles, for cumulative cycles 4, 9, 13, 16, 20 and 24 (counted from the first clock after reset release). wb_sel is 00, 01, 10 and 11 on the R, LW, JAL and LUI WB cycles respectively.
- LW with mem_ready low for 3 MEM cycles -> mem_read held 4 cycles; reg_write only in the following WB; no trap.
- mem_ready held low in FETCH -> trap=1 and trap_cause=1 after TIMEOUT_CYC=15 wait cycles; all enables stay 0 afterwards until reset.
- Opcode 1111111 at DECODE -> TRAP with trap_cause=0; no reg_write, mem_write or pc_write occurs after the fetch.
- mem_ready rises exactly on the 15th wait cycle -> access completes with no trap.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcodes, FSM states and control encodings for the multicycle controller
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI: is_legal = 1'b1;
      default:                                                  is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// rtl/ctrl_wait_timer.sv - saturating wait counter; at_limit marks the last allowed wait cycle
module ctrl_wait_timer #(
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed wait cycles, so this cycle is wait number TIMEOUT_CYC
  assign at_limit = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB with memory timeout trap
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter int ALUOP_W     = 2,
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                branch,
  output logic                jump,
  output logic                alu_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                retire,
  output logic                trap,
  output logic                trap_cause
);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                cause_q, cause_d;
  logic                at_limit;
  logic                timer_clr, timer_en;

  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui;
  assign is_r    = (op_q == OP_R);
  assign is_i    = (op_q == OP_I);
  assign is_lw   = (op_q == OP_LW);
  assign is_sw   = (op_q == OP_SW);
  assign is_br   = (op_q == OP_BR);
  assign is_jal  = (op_q == OP_JAL);
  assign is_jalr = (op_q == OP_JALR);
  assign is_lui  = (op_q == OP_LUI);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cause_d   = cause_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = DECODE;
        end else if (at_limit) begin
          state_d = TRAP;
          cause_d = 1'b1;
        end
      end
      DECODE: begin
        op_d = opcode;
        if (is_legal(opcode)) begin
          state_d = EXEC;
        end else begin
          state_d = TRAP;
          cause_d = 1'b0;
        end
      end
      EXEC: begin
        alu_src = is_i | is_lw | is_sw | is_jalr | is_lui;
        if (is_r)       alu_op = ALU_RTYPE;
        else if (is_i)  alu_op = ALU_ITYPE;
        else if (is_br) alu_op = ALU_BR;
        if (is_br) begin
          branch  = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (is_jal || is_jalr) begin
          jump     = 1'b1;
          pc_write = 1'b1;
          state_d  = WB;
        end else if (is_lw || is_sw) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_read  = is_lw;
        mem_write = is_sw;
        if (mem_ready) begin
          retire  = is_sw;
          state_d = is_sw ? FETCH : WB;
        end else if (at_limit) begin
          state_d = TRAP;
          cause_d = 1'b1;
        end
      end
      WB: begin
        reg_write = 1'b1;
        if (is_lw)                 wb_sel = WB_MEM;
        else if (is_jal || is_jalr) wb_sel = WB_PC4;
        else if (is_lui)           wb_sel = WB_IMM;
        retire  = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign trap       = (state_q == TRAP);
  assign trap_cause = cause_q;

  // Counter restarts whenever a new wait window opens or the memory answers
  assign timer_en  = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
  assign timer_clr = mem_ready ||
                     (((state_d == FETCH) || (state_d == MEM)) && (state_d != state_q));

  ctrl_wait_timer #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .at_limit(at_limit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench with a per-instruction reference model
module tb_multicycle_controller;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write, ir_write, branch, jump, alu_src;
  logic [1:0] alu_op;
  logic       mem_read, mem_write, reg_write;
  logic [1:0] wb_sel;
  logic       retire, trap, trap_cause;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .branch    (branch),
    .jump      (jump),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .retire    (retire),
    .trap      (trap),
    .trap_cause(trap_cause)
  );

  int checks = 0;
  int failures = 0;

  // memory responder: access k sees dly[k] low-ready cycles before completing
  int dly[2];
  int acc_idx, wcnt;
  logic req_s, rdy_s;

  int n_memr, n_memw, n_regw, n_pcw, n_irw, n_br, n_jmp, n_en;
  logic [1:0] wb_or, aop_or;
  logic asrc_or, ret_s, trap_s, cause_s;
  int total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_acc();
    n_memr = 0; n_memw = 0; n_regw = 0; n_pcw = 0; n_irw = 0;
    n_br = 0; n_jmp = 0; n_en = 0;
    wb_or = 2'b00; aop_or = 2'b00; asrc_or = 1'b0;
    ret_s = 1'b0; trap_s = 1'b0; cause_s = 1'b0;
  endtask

  task automatic step();
    logic req;
    req = mem_read | mem_write;
    mem_ready = req && (acc_idx >= 2 || wcnt >= dly[acc_idx]);
    @(negedge clk);
    n_memr += int'(mem_read);
    n_memw += int'(mem_write);
    n_regw += int'(reg_write);
    n_pcw  += int'(pc_write);
    n_irw  += int'(ir_write);
    n_br   += int'(branch);
    n_jmp  += int'(jump);
    if (reg_write) wb_or = wb_or | wb_sel;
    aop_or  = aop_or | alu_op;
    asrc_or = asrc_or | alu_src;
    ret_s   = retire;
    trap_s  = trap;
    cause_s = trap_cause;
    if (pc_write | ir_write | branch | jump | alu_src | (|alu_op) | mem_read |
        mem_write | reg_write | (|wb_sel) | retire) n_en++;
    req_s = mem_read | mem_write;
    rdy_s = mem_ready;
    @(posedge clk);
    #1;
    if (req_s && rdy_s) begin
      acc_idx++;
      wcnt = 0;
    end else if (req_s) begin
      wcnt++;
    end
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    opcode = OPC_R;
    dly[0] = 0; dly[1] = 0; acc_idx = 0; wcnt = 0;
    step();
    step();
    reset = 1'b1;
    acc_idx = 0; wcnt = 0;
  endtask

  // Reference: what one instruction should produce, from its class and wait counts
  task automatic model(input logic [6:0] op, input int fd, input int md,
                       output int lat, output int memr, output int memw, output int regw,
                       output int pcw, output int br, output int jmp,
                       output logic [1:0] wbs, output logic [1:0] aop, output logic asrc);
    lat = 4 + fd; memr = 1 + fd; memw = 0; regw = 1; pcw = 1; br = 0; jmp = 0;
    wbs = 2'd0; aop = 2'd0; asrc = 1'b0;
    case (op)
      OPC_R:    aop = 2'd2;
      OPC_I:    begin aop = 2'd3; asrc = 1'b1; end
      OPC_LW:   begin lat = 5 + fd + md; memr = 2 + fd + md; wbs = 2'd1; asrc = 1'b1; end
      OPC_SW:   begin lat = 4 + fd + md; memw = 1 + md; regw = 0; asrc = 1'b1; end
      OPC_BR:   begin lat = 3 + fd; regw = 0; br = 1; aop = 2'd1; end
      OPC_JAL:  begin pcw = 2; jmp = 1; wbs = 2'd2; end
      OPC_JALR: begin pcw = 2; jmp = 1; wbs = 2'd2; asrc = 1'b1; end
      OPC_LUI:  begin wbs = 2'd3; asrc = 1'b1; end
      default:  lat = 0;
    endcase
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input int fd, input int md);
    int n, lat, memr, memw, regw, pcw, br, jmp;
    logic [1:0] wbs, aop;
    logic asrc;
    opcode = op;
    dly[0] = fd; dly[1] = md; acc_idx = 0; wcnt = 0;
    clear_acc();
    n = 0;
    do begin
      step();
      n++;
    end while (!ret_s && n < 80);
    total += n;
    model(op, fd, md, lat, memr, memw, regw, pcw, br, jmp, wbs, aop, asrc);
    check({tag, "/latency"}, n, lat);
    check({tag, "/mem_read_cycles"}, n_memr, memr);
    check({tag, "/mem_write_cycles"}, n_memw, memw);
    check({tag, "/reg_write_cycles"}, n_regw, regw);
    check({tag, "/pc_write_cycles"}, n_pcw, pcw);
    check({tag, "/ir_write_cycles"}, n_irw, 1);
    check({tag, "/branch_cycles"}, n_br, br);
    check({tag, "/jump_cycles"}, n_jmp, jmp);
    check({tag, "/wb_sel"}, wb_or, wbs);
    check({tag, "/alu_op"}, aop_or, aop);
    check({tag, "/alu_src"}, asrc_or, asrc);
    check({tag, "/no_trap"}, trap_s, 1'b0);
  endtask

  logic [6:0] seq_ops[6];
  int         seq_cum[6];
  logic [6:0] legal[8];

  initial begin
    int n;
    reset = 1'b1; opcode = OPC_R; mem_ready = 1'b0;
    dly[0] = 0; dly[1] = 0; acc_idx = 0; wcnt = 0; total = 0;
    clear_acc();
    #2 reset = 1'b0;
    #1;
    check("reset/mem_read", mem_read, 1'b1);
    check("reset/enables", {pc_write, ir_write, branch, jump, alu_src, alu_op,
                            mem_write, reg_write, wb_sel, retire}, 0);
    check("reset/trap", {trap, trap_cause}, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    seq_ops = '{OPC_R, OPC_LW, OPC_SW, OPC_BR, OPC_JAL, OPC_LUI};
    seq_cum = '{4, 9, 13, 16, 20, 24};
    total = 0;
    for (int i = 0; i < 6; i++) begin
      run_instr($sformatf("seq%0d", i), seq_ops[i], 0, 0);
      check($sformatf("seq%0d/cumulative", i), total, seq_cum[i]);
    end

    run_instr("lw_wait3", OPC_LW, 0, 3);
    run_instr("fetch_ready_15th", OPC_R, 14, 0);
    run_instr("mem_ready_15th", OPC_LW, 0, 14);
    run_instr("sw_ready_15th", OPC_SW, 14, 14);

    legal = '{OPC_R, OPC_I, OPC_LW, OPC_SW, OPC_BR, OPC_JAL, OPC_JALR, OPC_LUI};
    for (int i = 0; i < 30; i++) begin
      int fd, md;
      logic [6:0] op;
      op = legal[$urandom_range(0, 7)];
      fd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : 0;
      md = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
      run_instr($sformatf("rnd%0d", i), op, fd, md);
    end

    // Async reset while SW holds mem_write in MEM
    do_reset();
    opcode = OPC_SW; dly[0] = 0; dly[1] = 10; acc_idx = 0; wcnt = 0;
    clear_acc();
    n = 0;
    while (n_memw < 2 && n < 20) begin
      step();
      n++;
    end
    check("swreset/reached_mem", n_memw, 2);
    check("swreset/mem_write_before", mem_write, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("swreset/mem_write", mem_write, 1'b0);
    check("swreset/fetch_mem_read", mem_read, 1'b1);
    check("swreset/reg_write", reg_write, 1'b0);
    check("swreset/trap", trap, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    acc_idx = 0; wcnt = 0;

    // Fetch timeout
    dly[0] = 1000; dly[1] = 0; acc_idx = 0; wcnt = 0;
    clear_acc();
    n = 0;
    while (!trap_s && n < 40) begin
      step();
      n++;
    end
    check("timeout/cycle_of_trap", n, 16);
    check("timeout/cause", cause_s, 1'b1);
    clear_acc();
    repeat (20) step();
    check("timeout/enables_after", n_en, 0);
    check("timeout/sticky", {trap_s, cause_s}, 2'b11);

    // Illegal opcode
    do_reset();
    opcode = OPC_BAD; dly[0] = 0; dly[1] = 0; acc_idx = 0; wcnt = 0;
    clear_acc();
    n = 0;
    while (!trap_s && n < 10) begin
      step();
      n++;
    end
    check("illegal/cycle_of_trap", n, 3);
    check("illegal/cause", cause_s, 1'b0);
    check("illegal/pc_write_only_fetch", n_pcw, 1);
    check("illegal/no_writes", n_regw + n_memw, 0);
    clear_acc();
    repeat (10) step();
    check("illegal/enables_after", n_en, 0);
    check("illegal/sticky", trap_s, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
